mem_port_arbiter: RTL

Sequencer and arbiter that shares one external memory port between the instruction-fetch stage and the MEM stage (loads/stores) of the 5-stage RV32I pipeline. It grants one requester at a time, drives the bus address/control/data lines, and waits for the active-low acknowledge. It returns read data with a one-cycle done pulse and raises a pipeline stall while any access is outstanding. An optional timeout aborts hung transfers.

---
 rtl/mem_port_arbiter_if.sv | 70 +++++++
 rtl/mem_port_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
//
// Bundles every signal of the shared memory port arbiter apart from clock and
// reset: the fetch requester, the data requester, the pipeline stall and the
// external memory bus.
//
// Modports:
//   slave  - the arbiter's view: takes requests and memory responses, drives
//            completions, stall and the bus address/control/data lines.
//   master - the environment's view (pipeline stages plus memory model).
//
// Signals:
//   if_req, if_addr[31:0]               fetch request, held until if_done
//   if_rdata[31:0], if_done             fetch result and completion pulse
//   d_req, d_write, d_size[1:0],
//   d_addr[31:0], d_wdata[31:0]         data request, held until d_done
//   d_rdata[31:0], d_done               load result and completion pulse
//   stall                               a request is still outstanding
//   bus_err                             the completing access timed out
//   bus_addr, bus_mreq, bus_write,
//   bus_size, bus_wdata, bus_wen        memory bus outputs
//   bus_rdata, bus_ack_n                memory bus inputs (ack active low)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;

    logic        d_req;
    logic        d_write;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;

    logic        stall;
    logic        bus_err;

    logic [31:0] bus_addr;
    logic        bus_mreq;
    logic        bus_write;
    logic [1:0]  bus_size;
    logic [31:0] bus_wdata;
    logic        bus_wen;
    logic [31:0] bus_rdata;
    logic        bus_ack_n;

    modport slave (
        input  if_req, if_addr,
        input  d_req, d_write, d_size, d_addr, d_wdata,
        input  bus_rdata, bus_ack_n,
        output if_rdata, if_done,
        output d_rdata, d_done,
        output stall, bus_err,
        output bus_addr, bus_mreq, bus_write, bus_size, bus_wdata, bus_wen
    );

    modport master (
        output if_req, if_addr,
        output d_req, d_write, d_size, d_addr, d_wdata,
        output bus_rdata, bus_ack_n,
        input  if_rdata, if_done,
        input  d_rdata, d_done,
        input  stall, bus_err,
        input  bus_addr, bus_mreq, bus_write, bus_size, bus_wdata, bus_wen
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one external memory port between the instruction-fetch stage and the
// MEM stage of a 5-stage RV32I pipeline. One requester is granted at a time;
// data wins over fetch because the MEM-stage instruction is older. The granted
// request is copied into registered bus outputs, the arbiter waits for the
// active-low acknowledge (or gives up after TIMEOUT cycles), then spends one
// response cycle pulsing the matching done with its read data.
//
// Cycle picture for a zero-wait access:
//   cycle 0 IDLE sees the request, cycle 1 bus driven and acked,
//   cycle 2 RESP (done pulse), cycle 3 back in IDLE.
//
// Parameters:
//   TIMEOUT  cycles a granted access may wait for acknowledge (1..255)
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset; abandons any access in flight
//   mp   mem_port_arbiter_if.slave - requests, completions, stall, memory bus
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     mp
);

    // The wait counter saturates one short of TIMEOUT: when it already holds
    // TIMEOUT-1 and the bus still has not acknowledged, this edge is the
    // TIMEOUT-th bus cycle and the access is aborted.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 32'd1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t      state_r,     state_s;
    logic [7:0]  cnt_r,       cnt_s;

    logic [31:0] bus_addr_r,  bus_addr_s;
    logic        bus_mreq_r,  bus_mreq_s;
    logic        bus_write_r, bus_write_s;
    logic        bus_wen_r,   bus_wen_s;
    logic [1:0]  bus_size_r,  bus_size_s;
    logic [31:0] bus_wdata_r, bus_wdata_s;

    logic        if_done_r,   if_done_s;
    logic        d_done_r,    d_done_s;
    logic        bus_err_r,   bus_err_s;
    logic [31:0] if_rdata_r,  if_rdata_s;
    logic [31:0] d_rdata_r,   d_rdata_s;

    logic        ack_s;
    logic        timeout_s;
    logic [31:0] resp_data_s;

    assign ack_s     = ~mp.bus_ack_n;
    assign timeout_s = (cnt_r == TIMEOUT_LAST);

    // A store has nothing to return, and an aborted access returns zero; in
    // both cases the response register is loaded with 0 rather than whatever
    // happens to be floating on bus_rdata.
    assign resp_data_s = (ack_s && !bus_write_r) ? mp.bus_rdata : 32'h0000_0000;

    // Next-state, bus-line and response decode for the sequencer.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        bus_addr_s  = bus_addr_r;
        bus_mreq_s  = bus_mreq_r;
        bus_write_s = bus_write_r;
        bus_wen_s   = bus_wen_r;
        bus_size_s  = bus_size_r;
        bus_wdata_s = bus_wdata_r;
        if_done_s   = 1'b0;
        d_done_s    = 1'b0;
        bus_err_s   = 1'b0;
        if_rdata_s  = if_rdata_r;
        d_rdata_s   = d_rdata_r;

        case (state_r)
            ST_IDLE: begin
                cnt_s = 8'd0;
                if (mp.d_req) begin
                    // Data first: the load/store belongs to the older instruction.
                    state_s     = ST_DATA;
                    bus_addr_s  = mp.d_addr;
                    bus_mreq_s  = 1'b1;
                    bus_write_s = mp.d_write;
                    bus_wen_s   = mp.d_write;
                    bus_size_s  = mp.d_size;
                    bus_wdata_s = mp.d_write ? mp.d_wdata : 32'h0000_0000;
                end else if (mp.if_req) begin
                    state_s     = ST_FETCH;
                    bus_addr_s  = mp.if_addr;
                    bus_mreq_s  = 1'b1;
                    bus_write_s = 1'b0;
                    bus_wen_s   = 1'b0;
                    bus_size_s  = 2'b10;
                    bus_wdata_s = 32'h0000_0000;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_FETCH, ST_DATA: begin
                if (ack_s || timeout_s) begin
                    // Ack is tested first, so an ack arriving on the timeout
                    // edge still completes cleanly with bus_err low.
                    state_s     = ST_RESP;
                    cnt_s       = 8'd0;
                    bus_addr_s  = 32'h0000_0000;
                    bus_mreq_s  = 1'b0;
                    bus_write_s = 1'b0;
                    bus_wen_s   = 1'b0;
                    bus_size_s  = 2'b00;
                    bus_wdata_s = 32'h0000_0000;
                    bus_err_s   = ~ack_s;
                    if (state_r == ST_FETCH) begin
                        if_done_s  = 1'b1;
                        if_rdata_s = resp_data_s;
                    end else begin
                        d_done_s  = 1'b1;
                        d_rdata_s = resp_data_s;
                    end
                end else begin
                    cnt_s = cnt_r + 8'd1;
                end
            end

            ST_RESP: begin
                // Requests are not looked at here; the requester updates its
                // inputs on this edge and the following IDLE sees them.
                state_s = ST_IDLE;
            end

            default: begin
                state_s     = ST_IDLE;
                cnt_s       = 8'd0;
                bus_addr_s  = 32'h0000_0000;
                bus_mreq_s  = 1'b0;
                bus_write_s = 1'b0;
                bus_wen_s   = 1'b0;
                bus_size_s  = 2'b00;
                bus_wdata_s = 32'h0000_0000;
            end
        endcase
    end

    // Sequencer state and wait-state counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= 8'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Registered memory bus address/control/data lines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_addr_r  <= 32'h0000_0000;
            bus_mreq_r  <= 1'b0;
            bus_write_r <= 1'b0;
            bus_wen_r   <= 1'b0;
            bus_size_r  <= 2'b00;
            bus_wdata_r <= 32'h0000_0000;
        end else begin
            bus_addr_r  <= bus_addr_s;
            bus_mreq_r  <= bus_mreq_s;
            bus_write_r <= bus_write_s;
            bus_wen_r   <= bus_wen_s;
            bus_size_r  <= bus_size_s;
            bus_wdata_r <= bus_wdata_s;
        end
    end

    // Completion pulses, error flag and per-port read data holding registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_done_r  <= 1'b0;
            d_done_r   <= 1'b0;
            bus_err_r  <= 1'b0;
            if_rdata_r <= 32'h0000_0000;
            d_rdata_r  <= 32'h0000_0000;
        end else begin
            if_done_r  <= if_done_s;
            d_done_r   <= d_done_s;
            bus_err_r  <= bus_err_s;
            if_rdata_r <= if_rdata_s;
            d_rdata_r  <= d_rdata_s;
        end
    end

    assign mp.bus_addr  = bus_addr_r;
    assign mp.bus_mreq  = bus_mreq_r;
    assign mp.bus_write = bus_write_r;
    assign mp.bus_wen   = bus_wen_r;
    assign mp.bus_size  = bus_size_r;
    assign mp.bus_wdata = bus_wdata_r;
    assign mp.if_done   = if_done_r;
    assign mp.d_done    = d_done_r;
    assign mp.bus_err   = bus_err_r;
    assign mp.if_rdata  = if_rdata_r;
    assign mp.d_rdata   = d_rdata_r;

    // Stall must react in the same cycle a request appears, so it is the one
    // combinational output; it drops in the done cycle of the last pending port.
    assign mp.stall = (mp.if_req & ~if_done_r) | (mp.d_req & ~d_done_r);

endmodule
